// File: rtl/fp_align_pkg.sv
// Shared defaults, shift-width helper and rounding-bit bundle for the FP alignment stage.
// FP_ALIGN_ROUND_BIT_EN adds a separate round bit R alongside G and PS.
package fp_align_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 25;
    localparam int TAG_W_DEF = 4;

    // Clamped shift amount must be able to hold MAN_W+1.
    function automatic int shift_w(input int man_w);
        return $clog2(man_w + 2);
    endfunction

    localparam int SHIFT_W = $clog2(MAN_W_DEF + 2);

    typedef struct packed {
`ifdef FP_ALIGN_ROUND_BIT_EN
        logic r;
`endif
        logic g;
        logic ps;
    } round_bits_t;

endpackage

// File: rtl/fp_align_if.sv
// Operand-in / aligned-result-out bundle of the FP alignment stage.
// FP_ALIGN_ROUND_BIT_EN adds the round bit r to the result side.
interface fp_align_if
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] ma;
    logic [MAN_W-1:0] mb;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] cexp;
    logic [MAN_W-1:0] mmax;
    logic [MAN_W-1:0] mmin;
    logic             g;
    logic             ps;
    logic             maxab;
    logic [TAG_W-1:0] out_tag;
`ifdef FP_ALIGN_ROUND_BIT_EN
    logic             r;

    modport master (
        output in_valid, ea, eb, ma, mb, in_tag, out_ready,
        input  in_ready, out_valid, cexp, mmax, mmin, g, r, ps, maxab, out_tag
    );

    modport slave (
        input  in_valid, ea, eb, ma, mb, in_tag, out_ready,
        output in_ready, out_valid, cexp, mmax, mmin, g, r, ps, maxab, out_tag
    );
`else
    modport master (
        output in_valid, ea, eb, ma, mb, in_tag, out_ready,
        input  in_ready, out_valid, cexp, mmax, mmin, g, ps, maxab, out_tag
    );

    modport slave (
        input  in_valid, ea, eb, ma, mb, in_tag, out_ready,
        output in_ready, out_valid, cexp, mmax, mmin, g, ps, maxab, out_tag
    );
`endif

endinterface

// File: rtl/fp_align_shifter.sv
// Combinational clamp + right shift of the smaller mantissa with G/(R)/PS generation.
// FP_ALIGN_ROUND_BIT_EN splits the round bit R out of the pre-sticky.
module fp_align_shifter
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [EXP_W-1:0] d,
    input  logic [MAN_W-1:0] m,
    output logic [MAN_W-1:0] mmin,
    output round_bits_t      rnd
);

    localparam int SW    = shift_w(MAN_W);
    localparam int BUF_W = 2 * MAN_W + 1;

    logic          clamp;
    logic [SW-1:0] s;
    logic [BUF_W-1:0] shifted;

    // Any shift beyond MAN_W+1 pushes every bit into the sticky region, so the
    // shifter only ever needs to handle 0..MAN_W+1.
    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branch, otherwise a path that skips it infers a latch.
        clamp   = (int'(d) > MAN_W + 1);
        s       = clamp ? SW'(MAN_W + 1) : SW'(d);
        shifted = {m, {(MAN_W + 1){1'b0}}} >> s;
        mmin    = shifted[BUF_W-1 -: MAN_W];
        rnd     = '0;
        rnd.g   = shifted[MAN_W];
`ifdef FP_ALIGN_ROUND_BIT_EN
        rnd.r   = shifted[MAN_W-1];
        rnd.ps  = |shifted[MAN_W-2:0];
        if (int'(d) > MAN_W + 1) begin
            rnd.r  = 1'b0;
            rnd.ps = |m;
        end
`else
        rnd.ps  = |shifted[MAN_W-1:0];
`endif
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage mantissa alignment: S1 compare/swap/exponent difference, S2 shift + rounding bits.
// FP_ALIGN_ROUND_BIT_EN adds the separate round bit output r.
module fp_align_pipe
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    fp_align_if.slave bus
);

    logic             b_larger;
    logic [EXP_W-1:0] emax;
    logic [EXP_W-1:0] emin;
    logic [MAN_W-1:0] mbig;
    logic [MAN_W-1:0] msmall;

    logic             s1_valid;
    logic             s1_ready;
    logic [EXP_W-1:0] s1_cexp;
    logic [EXP_W-1:0] s1_d;
    logic [MAN_W-1:0] s1_mmax;
    logic [MAN_W-1:0] s1_msmall;
    logic             s1_maxab;
    logic [TAG_W-1:0] s1_tag;

    logic [MAN_W-1:0] sh_mmin;
    round_bits_t      sh_rnd;

    logic             s2_valid;
    logic             s2_ready;
    logic [EXP_W-1:0] s2_cexp;
    logic [MAN_W-1:0] s2_mmax;
    logic [MAN_W-1:0] s2_mmin;
    round_bits_t      s2_rnd;
    logic             s2_maxab;
    logic [TAG_W-1:0] s2_tag;

    // Exponent-major compare; ties keep A as the larger operand.
    always_comb begin
        b_larger = {bus.eb, bus.mb} > {bus.ea, bus.ma};
        emax     = b_larger ? bus.eb : bus.ea;
        emin     = b_larger ? bus.ea : bus.eb;
        mbig     = b_larger ? bus.mb : bus.ma;
        msmall   = b_larger ? bus.ma : bus.mb;
    end

    // A stage may load whenever it is empty or its contents leave this cycle.
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign s1_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so every result output
        // reads zero while reset is held, not just the valid flag.
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_cexp   <= '0;
            s1_d      <= '0;
            s1_mmax   <= '0;
            s1_msmall <= '0;
            s1_maxab  <= 1'b0;
            s1_tag    <= '0;
        end else if (s1_ready) begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cexp   <= emax;
                s1_d      <= emax - emin;
                s1_mmax   <= mbig;
                s1_msmall <= msmall;
                s1_maxab  <= b_larger;
                s1_tag    <= bus.in_tag;
            end
        end
    end

    fp_align_shifter #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_shifter (
        .d    (s1_d),
        .m    (s1_msmall),
        .mmin (sh_mmin),
        .rnd  (sh_rnd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_cexp  <= '0;
            s2_mmax  <= '0;
            s2_mmin  <= '0;
            s2_rnd   <= '0;
            s2_maxab <= 1'b0;
            s2_tag   <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cexp  <= s1_cexp;
                s2_mmax  <= s1_mmax;
                s2_mmin  <= sh_mmin;
                s2_rnd   <= sh_rnd;
                s2_maxab <= s1_maxab;
                s2_tag   <= s1_tag;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.cexp      = s2_cexp;
    assign bus.mmax      = s2_mmax;
    assign bus.mmin      = s2_mmin;
    assign bus.g         = s2_rnd.g;
    assign bus.ps        = s2_rnd.ps;
    assign bus.maxab     = s2_maxab;
    assign bus.out_tag   = s2_tag;
`ifdef FP_ALIGN_ROUND_BIT_EN
    assign bus.r         = s2_rnd.r;
`endif

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe (EXP_W=8, MAN_W=25, TAG_W=4); honours FP_ALIGN_ROUND_BIT_EN.
module tb_fp_align_pipe;

    typedef struct packed {
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [24:0] ma;
        logic [24:0] mb;
        logic [3:0]  tag;
    } op_t;

    typedef struct packed {
        logic [7:0]  cexp;
        logic [24:0] mmax;
        logic [24:0] mmin;
        logic        g;
        logic        r;
        logic        ps;
        logic        maxab;
        logic [3:0]  tag;
    } res_t;

    logic clk;
    logic rst_n;

    fp_align_if #(.EXP_W(8), .MAN_W(25), .TAG_W(4)) bus ();

    fp_align_pipe #(.EXP_W(8), .MAN_W(25), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    res_t exp_q[$];

    logic in_fire;
    logic out_fire;
    logic obs_in_ready;
    logic obs_out_valid;
    res_t obs;

    // Reference alignment computed bit by bit, independent of the RTL buffer shift.
    function automatic res_t model(input op_t op);
        res_t        res;
        logic        b_gt;
        int          d;
        logic [24:0] m;
        res      = '0;
        b_gt     = {op.eb, op.mb} > {op.ea, op.ma};
        res.maxab = b_gt;
        res.cexp = b_gt ? op.eb : op.ea;
        res.mmax = b_gt ? op.mb : op.ma;
        m        = b_gt ? op.ma : op.mb;
        d        = b_gt ? int'(op.eb) - int'(op.ea) : int'(op.ea) - int'(op.eb);
        res.mmin = (d >= 25) ? 25'd0 : (m >> d);
        res.g    = (d >= 1 && d <= 25) ? m[d-1] : 1'b0;
`ifdef FP_ALIGN_ROUND_BIT_EN
        res.r    = (d >= 2 && d <= 26) ? m[d-2] : 1'b0;
        for (int i = 0; i < 25; i++) if (i <= d - 3) res.ps |= m[i];
`else
        for (int i = 0; i < 25; i++) if (i <= d - 2) res.ps |= m[i];
`endif
        res.tag  = op.tag;
        return res;
    endfunction

    function automatic op_t rand_op(input logic [3:0] tag);
        op_t op;
        int  dl[10] = '{0, 1, 2, 3, 23, 24, 25, 26, 27, 200};
        int  delta;
        int  lo;
        int  hi;
        delta = dl[$urandom_range(0, 9)];
        lo    = $urandom_range(0, 255);
        hi    = (lo + delta > 255) ? 255 : lo + delta;
        op.ma = ($urandom_range(0, 3) == 0) ? 25'($urandom) : {1'b1, 24'($urandom)};
        op.mb = ($urandom_range(0, 7) == 0) ? op.ma : {1'b1, 24'($urandom)};
        if ($urandom_range(0, 1) == 1) begin
            op.ea = 8'(hi);
            op.eb = 8'(lo);
        end else begin
            op.ea = 8'(lo);
            op.eb = 8'(hi);
        end
        op.tag = tag;
        return op;
    endfunction

    // One clock: drive just after the edge, sample once the combinational ready settles.
    task automatic cycle(input logic v, input op_t op, input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.ea        = op.ea;
        bus.eb        = op.eb;
        bus.ma        = op.ma;
        bus.mb        = op.mb;
        bus.in_tag    = op.tag;
        bus.out_ready = ordy;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        in_fire       = v && bus.in_ready;
        out_fire      = bus.out_valid && ordy;
        obs.cexp      = bus.cexp;
        obs.mmax      = bus.mmax;
        obs.mmin      = bus.mmin;
        obs.g         = bus.g;
        obs.ps        = bus.ps;
        obs.maxab     = bus.maxab;
        obs.tag       = bus.out_tag;
`ifdef FP_ALIGN_ROUND_BIT_EN
        obs.r         = bus.r;
`else
        obs.r         = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        n_vec++;
        if (obs_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b expected 0", obs_out_valid);
        end
        n_vec++;
        if (obs !== res_t'(0)) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_spec_vectors();
        op_t  ops[4];
        res_t want[4];
        ops[0]  = '{ea: 8'h80, eb: 8'h7E, ma: 25'h1000000, mb: 25'h1800000, tag: 4'h1};
        ops[1]  = '{ea: 8'h80, eb: 8'h7F, ma: 25'h1000000, mb: 25'h1000001, tag: 4'h2};
        ops[2]  = '{ea: 8'h10, eb: 8'h90, ma: 25'h1000003, mb: 25'h1000000, tag: 4'h3};
        ops[3]  = '{ea: 8'h7F, eb: 8'h7F, ma: 25'h1234567, mb: 25'h1234567, tag: 4'h4};
        want[0] = '{cexp: 8'h80, mmax: 25'h1000000, mmin: 25'h0600000, g: 1'b0, r: 1'b0,
                    ps: 1'b0, maxab: 1'b0, tag: 4'h1};
        want[1] = '{cexp: 8'h80, mmax: 25'h1000000, mmin: 25'h0800000, g: 1'b1, r: 1'b0,
                    ps: 1'b0, maxab: 1'b0, tag: 4'h2};
        want[2] = '{cexp: 8'h90, mmax: 25'h1000000, mmin: 25'h0000000, g: 1'b0, r: 1'b0,
                    ps: 1'b1, maxab: 1'b1, tag: 4'h3};
        want[3] = '{cexp: 8'h7F, mmax: 25'h1234567, mmin: 25'h1234567, g: 1'b0, r: 1'b0,
                    ps: 1'b0, maxab: 1'b0, tag: 4'h4};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, ops[i], 1'b1);
            n_vec++;
            if (in_fire !== 1'b1) begin
                n_err++;
                $display("FAIL spec%0d_accept: got in_ready=%b expected 1", i, obs_in_ready);
            end
            cycle(1'b0, '0, 1'b1);
            n_vec++;
            if (obs_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL spec%0d_early: got out_valid=%b expected 0 after 1 clk", i, obs_out_valid);
            end
            cycle(1'b0, '0, 1'b1);
            n_vec++;
            if (obs_out_valid !== 1'b1 || obs !== want[i]) begin
                n_err++;
                $display("FAIL spec%0d_result: got valid=%b %h expected valid=1 %h",
                         i, obs_out_valid, obs, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t  p[4];
        op_t  t[8];
        res_t held;
        res_t want;
        logic have_held = 1'b0;
        int   sent = 0;
        int   got  = 0;
        for (int i = 0; i < 4; i++) p[i] = rand_op(4'(8 + i));
        for (int c = 0; c < 40 && got < 4; c++) begin
            cycle(sent < 4, p[(sent < 4) ? sent : 0], c >= 5);
            if (c >= 2 && c <= 4) begin
                n_vec++;
                if (obs_in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready c%0d: got %b expected 0", c, obs_in_ready);
                end
                if (have_held) begin
                    n_vec++;
                    if (obs !== held || obs_out_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_stable c%0d: got %h expected %h", c, obs, held);
                    end
                end else begin
                    held      = obs;
                    have_held = 1'b1;
                end
            end
            if (in_fire) begin
                exp_q.push_back(model(p[sent]));
                sent++;
            end
            if (out_fire) begin
                want = exp_q.pop_front();
                got++;
                n_vec++;
                if (obs !== want) begin
                    n_err++;
                    $display("FAIL stall_order #%0d: got %h expected %h", got, obs, want);
                end
            end
        end
        n_vec++;
        if (got != 4) begin
            n_err++;
            $display("FAIL stall_drain: got %0d results expected 4", got);
        end
        // Full throughput with out_ready held high.
        for (int i = 0; i < 8; i++) t[i] = rand_op(4'(i));
        for (int c = 0; c < 10; c++) begin
            cycle(c < 8, t[(c < 8) ? c : 0], 1'b1);
            if (c < 8) begin
                n_vec++;
                if (obs_in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL tput_in_ready c%0d: got %b expected 1", c, obs_in_ready);
                end
            end
            if (c >= 2) begin
                n_vec++;
                if (obs_out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL tput_out_valid c%0d: got %b expected 1", c, obs_out_valid);
                end
            end
            if (in_fire) exp_q.push_back(model(t[c]));
            if (out_fire && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_vec++;
                if (obs !== want) begin
                    n_err++;
                    $display("FAIL tput_result c%0d: got %h expected %h", c, obs, want);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL tput_drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_random_stream();
        op_t  cur;
        res_t want;
        int   sent = 0;
        int   cyc  = 0;
        cur = rand_op(4'($urandom));
        while ((sent < 150 || exp_q.size() > 0) && cyc < 3000) begin
            cycle(sent < 150 && $urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0);
            cyc++;
            if (in_fire) begin
                exp_q.push_back(model(cur));
                sent++;
                cur = rand_op(4'($urandom));
            end
            if (out_fire) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: got %h expected no result", obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin
                        n_err++;
                        $display("FAIL rand_result: got %h expected %h", obs, want);
                    end
                end
            end
        end
        n_vec++;
        if (sent != 150 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_timeout: got sent=%0d pending=%0d expected 150/0", sent, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, rand_op(4'h5), 1'b0);
        cycle(1'b1, rand_op(4'h6), 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        n_vec++;
        if (obs_out_valid !== 1'b0 || obs !== res_t'(0)) begin
            n_err++;
            $display("FAIL midreset_clear: got valid=%b %h expected valid=0 0", obs_out_valid, obs);
        end
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, '0, 1'b1);
            n_vec++;
            if (obs_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_ghost c%0d: got out_valid=%b expected 0", c, obs_out_valid);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ea        = '0;
        bus.eb        = '0;
        bus.ma        = '0;
        bus.mb        = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
